updown_counter_gl: RTL and testbench

//   Loadable N-bit up/down modulo counter with registered wrap pulse and

---
 rtl/updown_counter_gl.sv | 101 ++++++++++
 tb/tb_updown_counter_gl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/updown_counter_gl.sv
// rtl/updown_counter_gl.sv - loadable up/down modulo counter with wrap pulse and terminal count
//
// Purpose:
//   N-bit up/down counter that counts modulo (p_max+1). A synchronous load
//   captures load_value, clamped to p_max. Load takes priority over enable.
//   wrap is a registered one-cycle pulse that marks the edge where the count
//   wrapped. tc is combinational and flags that the next enabled edge wraps
//   in the current direction.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (clears count and wrap)
//   en          count enable
//   dir         1 = count up, 0 = count down
//   load        synchronous load strobe (overrides en)
//   load_value  value captured on load, clamped to p_max
//   count       current count (registered)
//   wrap        one-cycle pulse after a wrapping edge (registered)
//   tc          terminal count: dir ? count==p_max : count==0

module updown_counter_gl #(
  parameter int p_nbits = 4,
  parameter int p_max   = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [p_nbits-1:0] load_value,
  output logic [p_nbits-1:0] count,
  output logic               wrap,
  output logic               tc
);

  localparam logic [p_nbits-1:0] MaxVal = p_nbits'(p_max);

  logic [p_nbits-1:0] count_q, count_d;
  logic               wrap_q, wrap_d;

  // Ripple carry/borrow chains: bit i toggles when all lower bits are
  // 1 (increment) or all lower bits are 0 (decrement).
  logic [p_nbits-1:0] carry, borrow;
  logic [p_nbits-1:0] inc_val, dec_val;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar i = 1; i < p_nbits; i++) begin : g_chain
    assign carry[i]  = carry[i-1]  &  count_q[i-1];
    assign borrow[i] = borrow[i-1] & ~count_q[i-1];
  end

  assign inc_val = count_q ^ carry;
  assign dec_val = count_q ^ borrow;

  logic at_max, at_zero;
  assign at_max  = (count_q == MaxVal);
  assign at_zero = (count_q == '0);

  // The wrap points are decoded from at_max/at_zero, so the raw binary
  // overflow of the ripple chain is never selected when p_max < 2^p_nbits-1.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_value > MaxVal) ? MaxVal : load_value;
    end else if (en) begin
      if (dir) begin
        if (at_max) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = inc_val;
        end
      end else begin
        if (at_zero) begin
          count_d = MaxVal;
          wrap_d  = 1'b1;
        end else begin
          count_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign tc    = dir ? at_max : at_zero;

endmodule

// File: tb/tb_updown_counter_gl.sv
// tb/tb_updown_counter_gl.sv - scoreboard bench for updown_counter_gl (p_max=9 and p_max=15)
module tb_updown_counter_gl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, dir, load;
  logic [3:0] load_value;
  logic [3:0] c9, c15;
  logic       w9, w15, t9, t15;

  updown_counter_gl #(.p_nbits(4), .p_max(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
    .load_value(load_value), .count(c9), .wrap(w9), .tc(t9)
  );

  updown_counter_gl #(.p_nbits(4), .p_max(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
    .load_value(load_value), .count(c15), .wrap(w15), .tc(t15)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c9;  int w9;  int t9;
    int c15; int w15; int t15;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   m9  = 0;
  int   m15 = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: modulo arithmetic on integers.
  function automatic int nxt(input int m, input int mx, input bit ld, input bit e,
                             input bit d, input int v, output int w);
    w = 0;
    if (ld) return (v > mx) ? mx : v;
    if (!e) return m;
    if (d) begin
      w = (m + 1 > mx) ? 1 : 0;
      return (m + 1) % (mx + 1);
    end
    w = (m == 0) ? 1 : 0;
    return (m + mx) % (mx + 1);
  endfunction

  function automatic int tcf(input int m, input int mx, input bit d);
    return d ? int'(m == mx) : int'(m == 0);
  endfunction

  task automatic cyc(input bit ld, input bit e, input bit d, input int v);
    exp_t x;
    @(negedge clk);
    load = ld; en = e; dir = d; load_value = v[3:0];
    m9  = nxt(m9,  9,  ld, e, d, v, x.w9);
    m15 = nxt(m15, 15, ld, e, d, v, x.w15);
    x.c9  = m9;  x.t9  = tcf(m9, 9, d);
    x.c15 = m15; x.t15 = tcf(m15, 15, d);
    q.push_back(x);
  endtask

  // Monitor: every edge with a pending expectation produces one comparison set.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("count9",  int'(c9),  e.c9);
      chk("wrap9",   int'(w9),  e.w9);
      chk("tc9",     int'(t9),  e.t9);
      chk("count15", int'(c15), e.c15);
      chk("wrap15",  int'(w15), e.w15);
      chk("tc15",    int'(t15), e.t15);
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; load_value = 4'd0;
    #12;
    chk("reset_count9", int'(c9), 0);
    chk("reset_wrap9",  int'(w9), 0);
    chk("reset_count15", int'(c15), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Count to 5, then reset mid-cycle without an edge.
    repeat (5) cyc(0, 1, 1, 0);
    @(posedge clk);
    #3;
    chk("pre_reset_count9", int'(c9), 5);
    rst_n = 1'b0;
    #1;
    chk("async_reset_count9", int'(c9), 0);
    chk("async_reset_wrap9",  int'(w9), 0);
    chk("async_reset_count15", int'(c15), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_count9", int'(c9), 0);
    chk("reset_hold_wrap9",  int'(w9), 0);
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    rst_n = 1'b1;
    m9 = 0; m15 = 0;

    // Up wrap: 11 edges.
    repeat (11) cyc(0, 1, 1, 0);
    // Down wrap from 1.
    cyc(1, 0, 0, 1);
    repeat (3) cyc(0, 1, 0, 0);
    // Load priority over en, and clamp.
    cyc(1, 1, 1, 12);
    cyc(1, 1, 0, 3);
    // Hold at 9.
    cyc(1, 0, 1, 9);
    repeat (4) cyc(0, 0, 1, 0);
    @(posedge clk);
    #3;
    chk("dirflip_tc9_before", int'(t9), 1);
    dir = 1'b0;
    #1;
    chk("dirflip_tc9_after", int'(t9), 0);
    dir = 1'b1;
    #1;
    chk("dirflip_tc9_back", int'(t9), 1);

    // Full range on the p_max=15 instance.
    cyc(1, 0, 1, 14);
    repeat (3) cyc(0, 1, 1, 0);
    cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 1), $urandom_range(0, 15));
    end

    @(negedge clk);
    @(negedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
